// File: rtl/mmu_dma_master_if.sv
// MMU core-side port owned by the DMA master while the arbiter grants it.
// The master drives address/write strobes; the MMU/arbiter side returns grant and read data.
interface mmu_dma_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] core_addr;
    logic        core_wr_ena;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;

    modport master (
        output bus_req, core_addr, core_wr_ena, core_wr_data,
        input  bus_gnt, core_rd_data
    );

    modport slave (
        input  bus_req, core_addr, core_wr_ena, core_wr_data,
        output bus_gnt, core_rd_data
    );
endinterface

// File: rtl/mmu_dma_master.sv
// Block copy/fill initiator on the MMU core port; fill support is compiled in with MMU_DMA_FILL_EN.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | source address on the bus, waiting for grant
// WAIT    | registered-read data returning (RD_LATENCY = 1 only)
// WRITE   | destination write, gated by grant
// DONE    | one-cycle completion pulse
module mmu_dma_master #(
    parameter int         LEN_W      = 16,
    parameter int         RD_LATENCY = 0,
    parameter logic [3:0] VRAM_BANK  = 4'h2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
`ifdef MMU_DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_left,
    mmu_dma_master_if.master bus
);

    generate
        if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
            $fatal(1, "mmu_dma_master: RD_LATENCY must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, dst_q, data_q, addr_hold;
    logic [31:0] core_addr_c;
    logic        rd_accept, wr_accept;
    logic        fill_start, fill_q;
    logic [31:0] fill_word;
    logic        take_start;

    // VRAM words are 16-bit and word-indexed; everything else is byte-addressed 32-bit.
    function automatic logic [31:0] addr_step(input logic [31:0] a);
        return (a[31:28] == VRAM_BANK) ? 32'd1 : 32'd4;
    endfunction

`ifdef MMU_DMA_FILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (take_start) begin
            fill_q <= fill_mode;
        end
    end
    assign fill_start = fill_mode;
    assign fill_word  = fill_value;
`else
    assign fill_start = 1'b0;
    assign fill_q     = 1'b0;
    assign fill_word  = 32'h0;
`endif

    assign take_start = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (fill_start) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.bus_gnt) begin
                    rd_accept = 1'b1;
                    state_d   = (RD_LATENCY == 1) ? S_WAIT : S_WRITE;
                end
            end
            S_WAIT: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.bus_gnt) begin
                    wr_accept = 1'b1;
                    if (words_left == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else if (!fill_q) begin
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= 32'h0;
            dst_q      <= 32'h0;
            data_q     <= 32'h0;
            addr_hold  <= 32'h0;
            words_left <= '0;
        end else begin
            if (take_start) begin
                src_q      <= src_addr;
                dst_q      <= dst_addr;
                words_left <= len;
                // Fill reuses the data register so core_wr_data needs no extra mux.
                if (fill_start && len != '0) begin
                    data_q <= fill_word;
                end
            end
            if (rd_accept) begin
                src_q <= src_q + addr_step(src_q);
            end
            // With registered RAM the read was issued in READ, so WAIT captures even without grant.
            if ((RD_LATENCY == 0 && rd_accept) || state_q == S_WAIT) begin
                data_q <= bus.core_rd_data;
            end
            if (wr_accept) begin
                dst_q      <= dst_q + addr_step(dst_q);
                words_left <= words_left - LEN_W'(1);
            end
            if (state_q == S_READ || state_q == S_WRITE) begin
                addr_hold <= core_addr_c;
            end
        end
    end

    always_comb begin
        core_addr_c = addr_hold;
        if (state_q == S_READ) begin
            core_addr_c = src_q;
        end else if (state_q == S_WRITE) begin
            core_addr_c = dst_q;
        end
    end

    assign bus.core_addr    = core_addr_c;
    assign bus.core_wr_data = data_q;
    assign bus.core_wr_ena  = (state_q == S_WRITE) && bus.bus_gnt;
    assign busy             = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign bus.bus_req      = busy;
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_mmu_dma_master.sv
// Scoreboard bench for mmu_dma_master: expected writes are queued from a reference model,
// a negedge monitor pops and compares each granted write. Define MMU_DMA_FILL_EN for fill tests.
module tb_mmu_dma_master;
    parameter int TB_RD_LAT = 0;
    localparam int         LEN_W = 16;
    localparam logic [3:0] VB    = 4'h2;
    localparam int         W     = (TB_RD_LAT == 1) ? 3 : 2;
    localparam int         LIMIT = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr, dst_addr;
    logic [LEN_W-1:0] len;
`ifdef MMU_DMA_FILL_EN
    logic             fill_mode;
    logic [31:0]      fill_value;
`endif
    logic             busy, done;
    logic [LEN_W-1:0] words_left;

    mmu_dma_master_if bus();

    mmu_dma_master #(.LEN_W(LEN_W), .RD_LATENCY(TB_RD_LAT), .VRAM_BANK(VB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
`ifdef MMU_DMA_FILL_EN
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Source memory contents: a fixed function of address (0x11,0x22,.. at 0x3000_0000).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h3000_0000;
        if (off < 32'h10 && off[1:0] == 2'b00) return 32'h11 * ((off >> 2) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] rd_q;
    always @(posedge clk) rd_q <= mem_word(bus.core_addr);
    assign bus.core_rd_data = (TB_RD_LAT == 1) ? rd_q : mem_word(bus.core_addr);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  total_writes = 0;
    int  exp_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: word i goes from src+sum(steps) to dst+sum(steps); step 1 in VRAM, else 4.
    task automatic push_model(input logic [31:0] s0, input logic [31:0] d0, input int n,
                              input bit fill, input logic [31:0] val);
        logic [31:0] s, d;
        s = s0;
        d = d0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({d, fill ? val : mem_word(s)});
            s = s + ((s[31:28] == VB) ? 32'd1 : 32'd4);
            d = d + ((d[31:28] == VB) ? 32'd1 : 32'd4);
        end
        exp_left = n;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (busy) chk("words_left", words_left, exp_left);
            if (bus.core_wr_ena) begin
                chk("wr_ena_needs_gnt", bus.bus_gnt, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual_addr=%0h required=none", bus.core_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.core_addr, e.addr);
                    chk("wr_data", bus.core_wr_data, e.data);
                end
                total_writes++;
                exp_left--;
            end
        end
    end

    // gmode: 0 constant grant, 1 five-cycle stall on the second write, 2 random grant.
    task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit fill, input logic [31:0] val, input int gmode, input bit poke);
        int cyc, busy_cnt, done_cyc, weff, exp_busy;
        cyc = 1;
        busy_cnt = 0;
        done_cyc = 0;
        weff = fill ? 1 : W;
        @(posedge clk); #1;
        push_model(s, d, n, fill, val);
        src_addr = s;
        dst_addr = d;
        len = n[LEN_W-1:0];
`ifdef MMU_DMA_FILL_EN
        fill_mode = fill;
        fill_value = val;
`endif
        start = 1'b1;
        bus.bus_gnt = 1'b1;
        @(posedge clk); #1;
        while (cyc < LIMIT) begin
            start = poke && (cyc == 2);
            if (start) begin
                src_addr = $urandom;
                dst_addr = $urandom;
                len = LEN_W'($urandom_range(1, 9));
            end
            case (gmode)
                1: bus.bus_gnt = !(cyc >= 2 * weff && cyc <= 2 * weff + 4);
                2: bus.bus_gnt = ($urandom_range(0, 3) != 0);
                default: bus.bus_gnt = 1'b1;
            endcase
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.bus_gnt = 1'b1;
        if (done_cyc == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, LIMIT);
        end else if (gmode != 2) begin
            exp_busy = (n == 0) ? 0 : weff * n + ((gmode == 1) ? 5 : 0);
            chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
            chk({tag, "_done_cycle"}, done_cyc, exp_busy + 1);
        end
        @(negedge clk);
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_all_written"}, exp_q.size(), 0);
        chk({tag, "_words_left_end"}, words_left, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bus_req"}, bus.bus_req, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_ena"}, bus.core_wr_ena, 0);
        chk({tag, "_core_addr"}, bus.core_addr, 0);
        chk({tag, "_core_wr_data"}, bus.core_wr_data, 0);
        chk({tag, "_words_left"}, words_left, 0);
    endtask

    task automatic reset_abort();
        int base, waited;
        base = total_writes;
        waited = 0;
        @(posedge clk); #1;
        push_model(32'h0000_1000, 32'h0000_2000, 6, 1'b0, 32'h0);
        src_addr = 32'h0000_1000;
        dst_addr = 32'h0000_2000;
        len = LEN_W'(6);
`ifdef MMU_DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        start = 1'b1;
        bus.bus_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (total_writes < base + 2 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold_done", done, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_done", done, 0);
            chk("post_reset_busy", busy, 0);
        end
        chk("writes_before_abort", total_writes, base + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bases [5];
        logic [31:0] rs, rd;
        bit          rf;
        bases[0] = 32'h0000_4000;
        bases[1] = 32'h2000_0100;
        bases[2] = 32'h3000_0200;
        bases[3] = 32'hFFFF_FFF4;
        bases[4] = 32'h2FFF_FFFE;

        rst = 1'b1;
        start = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        len = '0;
`ifdef MMU_DMA_FILL_EN
        fill_mode = 1'b0;
        fill_value = 32'h0;
`endif
        bus.bus_gnt = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_xfer("copy_basic", 32'h3000_0000, 32'h3000_0100, 4, 1'b0, 32'h0, 0, 1'b0);
        run_xfer("copy_vram", 32'h0000_0040, 32'h2000_0000, 3, 1'b0, 32'h0, 0, 1'b0);
        run_xfer("grant_stall", 32'h0000_0400, 32'h0000_0800, 4, 1'b0, 32'h0, 1, 1'b0);
        run_xfer("len_zero", 32'h0000_0400, 32'h0000_0800, 0, 1'b0, 32'h0, 0, 1'b0);
        run_xfer("start_while_busy", 32'h3000_0000, 32'h2000_0040, 5, 1'b0, 32'h0, 0, 1'b1);
        run_xfer("addr_wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b0, 32'h0, 0, 1'b0);
        reset_abort();
        run_xfer("after_reset", 32'h3000_0000, 32'h0000_3000, 4, 1'b0, 32'h0, 0, 1'b0);
`ifdef MMU_DMA_FILL_EN
        run_xfer("fill_vram", 32'h0, 32'h2000_0010, 5, 1'b1, 32'h0000_DEAD, 0, 1'b0);
        run_xfer("fill_stall", 32'h0, 32'h0000_5000, 4, 1'b1, 32'hCAFE_F00D, 1, 1'b0);
        run_xfer("fill_zero", 32'h0, 32'h2000_0010, 0, 1'b1, 32'h1234_5678, 0, 1'b0);
`endif
        for (int i = 0; i < 20; i++) begin
            rs = bases[$urandom_range(0, 4)] + {$urandom_range(0, 15), 2'b00};
            rd = bases[$urandom_range(0, 4)] + {$urandom_range(0, 15), 2'b00};
`ifdef MMU_DMA_FILL_EN
            rf = $urandom_range(0, 1) == 1;
`else
            rf = 1'b0;
`endif
            run_xfer("random", rs, rd, $urandom_range(1, 8), rf, $urandom,
                     ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
